// File: rtl/memory_arbiter.sv
// Two-port memory arbiter: data accesses win over instruction fetch, a streak
// limit bounds fetch starvation, and responses return one cycle later to the port that owned the transfer.
module memory_arbiter #(
   parameter int unsigned MAX_STREAK = 4
) (
   input  logic        clk,
   input  logic        reset,
   // instruction-fetch port
   input  logic        i_req,
   input  logic [31:0] i_addr,
   input  logic [1:0]  i_prot,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        i_abort,
   // load/store data port
   input  logic        d_req,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic        d_write,
   input  logic [1:0]  d_size,
   input  logic [1:0]  d_prot,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_abort,
   // memory bus
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_write,
   output logic [1:0]  mem_size,
   output logic [1:0]  mem_prot,
   output logic [1:0]  mem_trans,
   input  logic [31:0] mem_rdata,
   input  logic        mem_abort
);

   localparam logic [3:0] STREAK_LIMIT = 4'(MAX_STREAK);

   typedef enum logic [1:0] {
      OWN_NONE = 2'b00,
      OWN_I    = 2'b01,
      OWN_D    = 2'b10
   } owner_t;

   typedef enum logic [1:0] {
      TR_IDLE = 2'b00,
      TR_NSEQ = 2'b10,
      TR_SEQ  = 2'b11
   } trans_t;

   owner_t      owner, owner_next;
   logic [3:0]  streak, streak_next;

   logic        prev_valid;
   logic        prev_is_d;
   logic        prev_write;
   logic [31:0] prev_addr;

   logic        grant_i, grant_d;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_write;
   logic [1:0]  bus_size, bus_prot;
   trans_t      bus_trans;
   logic        seq_hit;

   // Arbitration: data first unless the fetch has waited out the streak limit.
   always_comb begin
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (!reset) begin
         if (d_req && (!i_req || streak != STREAK_LIMIT)) begin
            grant_d = 1'b1;
         end else if (i_req) begin
            grant_i = 1'b1;
         end
      end
   end

   always_comb begin
      streak_next = streak;
      if (grant_i || !i_req) begin
         streak_next = '0;
      end else if (grant_d && streak != STREAK_LIMIT) begin
         streak_next = streak + 4'd1;
      end
   end

   always_comb begin
      bus_addr  = '0;
      bus_wdata = '0;
      bus_write = 1'b0;
      bus_size  = '0;
      bus_prot  = '0;
      if (grant_d) begin
         bus_addr  = d_addr;
         bus_wdata = d_wdata;
         bus_write = d_write;
         bus_size  = d_size;
         bus_prot  = d_prot;
      end else if (grant_i) begin
         bus_addr  = i_addr;
         bus_size  = 2'b10;
         bus_prot  = i_prot;
      end
   end

   // The all-ones check keeps the 32-bit wrap to zero from counting as sequential.
   always_comb begin
      seq_hit = prev_valid
             && (prev_is_d == grant_d)
             && (prev_write == bus_write)
             && (prev_addr != '1)
             && (bus_addr == prev_addr + 32'd1);
      bus_trans = TR_IDLE;
      if (grant_i || grant_d) begin
         bus_trans = seq_hit ? TR_SEQ : TR_NSEQ;
      end
   end

   always_comb begin
      owner_next = OWN_NONE;
      if (grant_d) begin
         owner_next = OWN_D;
      end else if (grant_i) begin
         owner_next = OWN_I;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner      <= OWN_NONE;
         streak     <= '0;
         prev_valid <= 1'b0;
         prev_is_d  <= 1'b0;
         prev_write <= 1'b0;
         prev_addr  <= '0;
      end else begin
         owner      <= owner_next;
         streak     <= streak_next;
         prev_valid <= grant_i | grant_d;
         prev_is_d  <= grant_d;
         prev_write <= bus_write;
         prev_addr  <= bus_addr;
      end
   end

   assign i_gnt     = grant_i;
   assign d_gnt     = grant_d;
   assign mem_addr  = bus_addr;
   assign mem_wdata = bus_wdata;
   assign mem_write = bus_write;
   assign mem_size  = bus_size;
   assign mem_prot  = bus_prot;
   assign mem_trans = bus_trans;

   // Reset gating here drops the response of a transfer granted just before reset.
   always_comb begin
      i_rvalid = (owner == OWN_I) && !reset;
      d_rvalid = (owner == OWN_D) && !reset;
      i_rdata  = i_rvalid ? mem_rdata : '0;
      i_abort  = i_rvalid ? mem_abort : 1'b0;
      d_rdata  = d_rvalid ? mem_rdata : '0;
      d_abort  = d_rvalid ? mem_abort : 1'b0;
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: grant/bus checks inline, responses checked
// by a scoreboard monitor against expectations queued at grant time.
module tb_memory_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic [1:0]  i_prot;
   logic        i_gnt, i_rvalid, i_abort;
   logic [31:0] i_rdata;
   logic        d_req;
   logic [31:0] d_addr, d_wdata;
   logic        d_write;
   logic [1:0]  d_size, d_prot;
   logic        d_gnt, d_rvalid, d_abort;
   logic [31:0] d_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_write, mem_abort;
   logic [1:0]  mem_size, mem_prot, mem_trans;

   localparam logic [1:0] T_IDLE = 2'b00;
   localparam logic [1:0] T_NSEQ = 2'b10;
   localparam logic [1:0] T_SEQ  = 2'b11;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   logic abort_flag = 1'b0;

   typedef struct {
      int          due;
      logic [31:0] data;
      logic        abort;
      logic        chk;
   } resp_t;

   resp_t iq[$];
   resp_t dq[$];
   logic [31:0] mem [logic [31:0]];

   memory_arbiter #(.MAX_STREAK(4)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_prot(i_prot), .i_gnt(i_gnt),
      .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_abort(i_abort),
      .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_write(d_write),
      .d_size(d_size), .d_prot(d_prot), .d_gnt(d_gnt),
      .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_abort(d_abort),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
      .mem_size(mem_size), .mem_prot(mem_prot), .mem_trans(mem_trans),
      .mem_rdata(mem_rdata), .mem_abort(mem_abort)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Unwritten words read back as addr ^ 0xA5A50000.
   function automatic logic [31:0] mw(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   always @(posedge clk) begin
      if (mem_trans != T_IDLE) begin
         mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : mw(mem_addr);
         mem_abort <= abort_flag;
         if (mem_write) mem[mem_addr] = mem_wdata;
      end else begin
         mem_rdata <= '0;
         mem_abort <= 1'b0;
      end
   end

   task automatic check_port(input string pn, input logic rv, input logic [31:0] rd,
                             input logic ab, inout resp_t q[$]);
      resp_t e;
      if (rv) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected: rvalid=1 at cycle %0d, required no response", pn, cyc);
         end else begin
            e = q.pop_front();
            if (e.due != cyc || ab !== e.abort || (e.chk && rd !== e.data)) begin
               errors++;
               $display("FAIL %s_resp: cycle=%0d rdata=%h abort=%b, required cycle=%0d rdata=%h abort=%b",
                        pn, cyc, rd, ab, e.due, e.data, e.abort);
            end
         end
      end else begin
         checks++;
         if (rd !== '0 || ab !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: rdata=%h abort=%b, required 0/0", pn, rd, ab);
         end
         if (q.size() != 0 && q[0].due <= cyc) begin
            checks++;
            errors++;
            $display("FAIL %s_missing: no rvalid at cycle %0d, required at %0d", pn, cyc, q[0].due);
            void'(q.pop_front());
         end
      end
   endtask

   always @(negedge clk) begin
      check_port("i", i_rvalid, i_rdata, i_abort, iq);
      check_port("d", d_rvalid, d_rdata, d_abort, dq);
   end

   task automatic check_grant(input string name, input logic ei, input logic ed,
                              input logic [1:0] et, input logic [31:0] ea,
                              input logic [31:0] edata, input logic chk);
      @(negedge clk);
      checks++;
      if (i_gnt !== ei || d_gnt !== ed) begin
         errors++;
         $display("FAIL %s_gnt: i=%b d=%b, required i=%b d=%b", name, i_gnt, d_gnt, ei, ed);
      end
      checks++;
      if (mem_trans !== et) begin
         errors++;
         $display("FAIL %s_trans: %b, required %b", name, mem_trans, et);
      end
      checks++;
      if (mem_addr !== ea) begin
         errors++;
         $display("FAIL %s_addr: %h, required %h", name, mem_addr, ea);
      end
      if (ei) iq.push_back('{due: cyc + 1, data: edata, abort: abort_flag, chk: chk});
      if (ed) dq.push_back('{due: cyc + 1, data: edata, abort: abort_flag, chk: chk});
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [9:0]    pat_i;
      bit [9:0]    pat_s;
      logic [31:0] ia, da;
      int          ic, dc;

      reset = 1'b1;
      i_req = 1'b1; i_addr = 32'h10; i_prot = 2'b01;
      d_req = 1'b1; d_addr = 32'h99; d_wdata = '0; d_write = 1'b0;
      d_size = 2'b10; d_prot = 2'b10;
      @(posedge clk);
      #1;

      check_grant("rst_hold0", 0, 0, T_IDLE, 32'h0, '0, 0);
      check_grant("rst_hold1", 0, 0, T_IDLE, 32'h0, '0, 0);

      reset = 1'b0;
      d_req = 1'b0;
      checks++;
      if ({i_rvalid, i_abort, i_rdata, d_rvalid, d_abort, d_rdata} !== '0) begin
         errors++;
         $display("FAIL rst_outputs: i=%b/%b/%h d=%b/%b/%h, required all 0",
                  i_rvalid, i_abort, i_rdata, d_rvalid, d_abort, d_rdata);
      end
      check_grant("rst_release", 1, 0, T_NSEQ, 32'h10, 32'hA5A5_0010, 1);

      i_addr = 32'h20;       check_grant("seq20", 1, 0, T_NSEQ, 32'h20, 32'hA5A5_0020, 1);
      i_addr = 32'h21;       check_grant("seq21", 1, 0, T_SEQ,  32'h21, 32'hA5A5_0021, 1);
      i_addr = 32'h22;       check_grant("seq22", 1, 0, T_SEQ,  32'h22, 32'hA5A5_0022, 1);
      i_addr = 32'h30;       check_grant("seq30", 1, 0, T_NSEQ, 32'h30, 32'hA5A5_0030, 1);
      i_addr = 32'hFFFFFFFF; check_grant("wrap_hi", 1, 0, T_NSEQ, 32'hFFFFFFFF, 32'h5A5A_FFFF, 1);
      i_addr = 32'h0;        check_grant("wrap_lo", 1, 0, T_NSEQ, 32'h0, 32'hA5A5_0000, 1);

      i_req = 1'b0;
      check_grant("idle0", 0, 0, T_IDLE, 32'h0, '0, 0);

      // Contention with MAX_STREAK=4: D,D,D,D,I repeating.
      pat_i = 10'b10000_10000;
      pat_s = 10'b01110_01110;
      ic = 0;
      dc = 0;
      for (int k = 0; k < 10; k++) begin
         ia = 32'h200 + 32'(ic);
         da = 32'h100 + 32'(dc);
         i_req = 1'b1; i_addr = ia;
         d_req = 1'b1; d_addr = da; d_write = 1'b0;
         check_grant($sformatf("contend%0d", k), pat_i[k], !pat_i[k],
                     pat_s[k] ? T_SEQ : T_NSEQ, pat_i[k] ? ia : da,
                     pat_i[k] ? mw(ia) : mw(da), 1);
         if (pat_i[k]) ic++;
         else dc++;
      end
      i_req = 1'b0;
      d_req = 1'b0;
      check_grant("idle1", 0, 0, T_IDLE, 32'h0, '0, 0);

      d_req = 1'b1; d_write = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
      #1;
      checks++;
      if (mem_write !== 1'b1 || mem_wdata !== 32'hDEADBEEF || mem_size !== 2'b10) begin
         errors++;
         $display("FAIL store_bus: write=%b wdata=%h size=%b, required 1/deadbeef/10",
                  mem_write, mem_wdata, mem_size);
      end
      check_grant("store", 0, 1, T_NSEQ, 32'h40, '0, 0);
      d_write = 1'b0; d_wdata = '0;
      check_grant("load", 0, 1, T_NSEQ, 32'h40, 32'hDEADBEEF, 1);

      d_addr = 32'h50;
      abort_flag = 1'b1;
      check_grant("abort_load", 0, 1, T_NSEQ, 32'h50, 32'hA5A5_0050, 1);
      abort_flag = 1'b0;
      d_req = 1'b0;
      check_grant("idle2", 0, 0, T_IDLE, 32'h0, '0, 0);

      // Fetch granted right before reset must produce no response.
      i_req = 1'b1; i_addr = 32'h60;
      check_grant("pre_rst", 1, 0, T_NSEQ, 32'h60, '0, 0);
      void'(iq.pop_back());
      reset = 1'b1; i_addr = 32'h61;
      check_grant("rst_mid", 0, 0, T_IDLE, 32'h0, '0, 0);
      reset = 1'b0;
      check_grant("post_rst", 1, 0, T_NSEQ, 32'h61, 32'hA5A5_0061, 1);
      i_req = 1'b0;

      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (iq.size() != 0 || dq.size() != 0) begin
         errors++;
         $display("FAIL drain: pending i=%0d d=%0d, required 0/0", iq.size(), dq.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single-ported `memory_controller` between the instruction-fetch port and the load/store data port of the processor. Each cycle it grants at most one request and drives the memory bus (`addr`, `wdata`, `write`, `size`, `prot`, `trans`). It returns read data and abort status one cycle later to the port that owns the transfer. Data accesses have priority, and a streak limit keeps instruction fetch from being starved.

## Interface
- `MAX_STREAK`, default 4: maximum consecutive data grants while a fetch is pending; legal range 1–15.
- `clk` input 1: clock; everything samples on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `i_req` input 1: fetch request; held with its fields stable until `i_gnt`.
- `i_addr` input 32: fetch word address.
- `i_prot` input 2: fetch protection attribute.
- `i_gnt` output 1: fetch request accepted this cycle.
- `i_rvalid` output 1: fetch response valid.
- `i_rdata` output 32: fetch read data.
- `i_abort` output 1: fetch response aborted.
- `d_req` input 1: data request; held stable until `d_gnt`.
- `d_addr` input 32: data word address.
- `d_wdata` input 32: store data.
- `d_write` input 1: 1 = store, 0 = load.
- `d_size` input 2: 00 byte, 01 halfword, 10 word; passed through.
- `d_prot` input 2: data protection attribute.
- `d_gnt` output 1: data request accepted.
- `d_rvalid` output 1: data response valid; for stores it is the write acknowledge.
- `d_rdata` output 32: load data.
- `d_abort` output 1: data response aborted.
- `mem_addr` output 32, `mem_wdata` output 32, `mem_write` output 1, `mem_size` output 2, `mem_prot` output 2, `mem_trans` output 2: memory bus.
- `mem_rdata` input 32, `mem_abort` input 1: memory response, valid in the cycle after the request.

## Operation
- **Grant (combinational from inputs and registered state):**
  - Only `d_req`: `d_gnt` = 1.
  - Only `i_req`: `i_gnt` = 1.
  - Both: `d_gnt`, unless `streak == MAX_STREAK`, in which case `i_gnt`.
  - `i_gnt` and `d_gnt` are never both high.
- **`streak` counter (4-bit):**
  - Increments on each cycle with `d_gnt & i_req`.
  - Clears on any cycle with `i_gnt` or with `!i_req`.
  - Saturates at `MAX_STREAK`.
- **Bus drive:**
  - On a grant, `mem_*` carry the winner's fields. Fetch drives `write` = 0, `size` = 10, `wdata` = 0.
  - With no grant: `mem_trans` = 00 (IDLE), `mem_write` = 0, `mem_addr`/`mem_wdata` = 0.
- **`mem_trans` on a grant:**
  - 11 (SEQ) if the previous cycle also granted the same port with the same `write` value and `addr == prev_addr + 1`.
  - Otherwise 10 (NSEQ).
  - The wrap from 0xFFFFFFFF to 0x00000000 is NSEQ.
- **Response routing:**
  - Register `owner` (none/I/D) at each edge from this cycle's grant.
  - In the next cycle, assert `owner`'s `rvalid` with `rdata = mem_rdata` and `abort = mem_abort`.
  - The other port's `rvalid`, `rdata` and `abort` are 0.
  - Aborted transfers are not retried; the requester decides what to do.
- **Back-to-back:** one transfer per cycle. A port may be granted on consecutive cycles, and a response and a new grant for the same port can coincide.

## Timing
- **Reset (cycle after `reset` is sampled high):**
  - `streak` = 0, `owner` = none, previous-grant record cleared.
  - All `*_rvalid`/`*_abort` = 0; `*_rdata` = 0.
  - While `reset` is high, `i_gnt` = `d_gnt` = 0 and `mem_trans` = 00 regardless of requests.
- **Reset mid-operation:** a transfer granted in the cycle before reset gets no response; its `rvalid` is suppressed.
- **Grant latency:** 0 cycles; a request is granted in the cycle it is presented, if it wins.
- **Response latency:** exactly 1 cycle after the grant, for both loads and stores.
- **Request changes:** a requester must not change its fields while `req` is high and `gnt` is low. Dropping `req` before a grant is allowed and discards the request.
- **Starvation bound:** with both ports continuously requesting, the fetch port is granted at least once every `MAX_STREAK + 1` cycles.

## Test plan
- **Reset:** hold `reset` 2 cycles with both requests high -> no grants, `mem_trans` = 00. On release with only `i_req` (addr 0x10) -> `i_gnt` = 1, `mem_trans` = 10. Next cycle `i_rvalid` = 1 and `i_rdata` equals memory word 0x10.
- **Sequential fetch:** fetch addrs 0x20, 0x21, 0x22 on consecutive cycles -> `mem_trans` 10, 11, 11. Fetch 0x30 next -> 10. Fetch 0xFFFFFFFF then 0x0 -> 10, 10.
- **Contention:** `MAX_STREAK` = 4, both ports requesting continuously -> grant pattern D,D,D,D,I repeating. `streak` returns to 0 after each I grant.
- **Store then load:** store 0xDEADBEEF to 0x40, then load 0x40 -> `d_rvalid` on both response cycles, load `d_rdata` = 0xDEADBEEF. The store-to-load transition is NSEQ even though the address is unchanged.
- **Abort routing:** `mem_abort` = 1 in the response cycle of a data load -> `d_abort` = 1, `d_rvalid` = 1, `i_rvalid` = 0, `i_abort` = 0.
- **Reset mid-transfer:** grant a fetch at cycle N, assert `reset` at cycle N+1 -> `i_rvalid` stays 0 at N+1. After release, the first grant is NSEQ.
